// File: rtl/punc_dmem_arbiter_pkg.sv
// punc_dmem_arbiter_pkg: shared arbiter state/owner encodings and width helper
package punc_dmem_arbiter_pkg;
  typedef enum logic [1:0] {ARB_ST_IDLE, ARB_ST_ISSUE, ARB_ST_WAIT, ARB_ST_ACK} arb_st_e;
  typedef enum logic {ARB_OWNER_CPU, ARB_OWNER_DBG} arb_owner_e;
  function automatic int cw(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/punc_dmem_arbiter_starve_cnt.sv
// punc_arb_starve_cnt: saturating count of CPU grants taken over a waiting debug request
module punc_arb_starve_cnt
  import punc_dmem_arbiter_pkg::*;
#(
  parameter int DBG_MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);
  localparam int W = cw(DBG_MAX_WAIT + 1);
  logic [W-1:0] cnt;
  assign at_max = cnt == W'(DBG_MAX_WAIT);
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (inc && !at_max) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/punc_dmem_arbiter.sv
// punc_dmem_arbiter: serialises CPU and debug accesses onto the single data-memory port
module punc_dmem_arbiter
  import punc_dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int MEM_LAT      = 1,
  parameter int DBG_MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  localparam int LW = cw(MEM_LAT);
  arb_st_e st, st_n;
  arb_owner_e own;
  logic we_q, at_max, grant, grant_dbg, done;
  logic [LW-1:0] cnt;
  punc_arb_starve_cnt #(.DBG_MAX_WAIT(DBG_MAX_WAIT)) u_starve (
    .clk(clk),
    .rst(rst),
    .inc(grant && !grant_dbg && dbg_req),
    .clr(grant && grant_dbg),
    .at_max(at_max)
  );
  always_comb begin
    grant = st == ARB_ST_IDLE && (cpu_req || dbg_req);
    grant_dbg = dbg_req && (!cpu_req || at_max);
    done = st == ARB_ST_WAIT && cnt == '0;
    st_n = st == ARB_ST_IDLE  ? (grant ? ARB_ST_ISSUE : ARB_ST_IDLE) :
           st == ARB_ST_ISSUE ? ARB_ST_WAIT :
           st == ARB_ST_WAIT  ? (done ? ARB_ST_ACK : ARB_ST_WAIT) : ARB_ST_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= ARB_ST_IDLE;
      own <= ARB_OWNER_CPU;
      we_q <= 1'b0;
      cnt <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
      dbg_rdata <= '0;
    end else begin
      st <= st_n;
      if (grant) begin
        own <= grant_dbg ? ARB_OWNER_DBG : ARB_OWNER_CPU;
        we_q <= grant_dbg ? dbg_we : cpu_we;
        mem_addr <= grant_dbg ? dbg_addr : cpu_addr;
        mem_wdata <= grant_dbg ? dbg_wdata : cpu_wdata;
      end
      if (st == ARB_ST_ISSUE) cnt <= LW'(MEM_LAT - 1);
      else if (st == ARB_ST_WAIT && !done) cnt <= cnt - 1'b1;
      if (done && !we_q && own == ARB_OWNER_CPU) cpu_rdata <= mem_rdata;
      if (done && !we_q && own == ARB_OWNER_DBG) dbg_rdata <= mem_rdata;
    end
  end
  assign mem_en = st == ARB_ST_ISSUE;
  assign mem_we = mem_en && we_q;
  assign busy = st != ARB_ST_IDLE;
  assign cpu_ack = st == ARB_ST_ACK && own == ARB_OWNER_CPU;
  assign dbg_ack = st == ARB_ST_ACK && own == ARB_OWNER_DBG;
endmodule

// File: tb/tb_punc_dmem_arbiter.sv
// tb_punc_dmem_arbiter: randomized transaction-level scoreboard bench for punc_dmem_arbiter
module tb_punc_dmem_arbiter;
  localparam int LAT = 1, MAXW = 4, LAT3 = 3;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic cpu_req = 0, cpu_we = 0, dbg_req = 0, dbg_we = 0;
  logic [15:0] cpu_addr = 0, cpu_wdata = 0, dbg_addr = 0, dbg_wdata = 0, mem_rdata = 0;
  logic cpu_ack, dbg_ack, mem_en, mem_we, busy;
  logic [15:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata;
  logic l3_req = 0;
  logic [15:0] l3_addr = 0, l3_mem_rdata = 0;
  logic l3_ack, l3_dack, l3_mem_en, l3_mem_we, l3_busy;
  logic [15:0] l3_rdata, l3_drdata, l3_mem_addr, l3_mem_wdata;
  punc_dmem_arbiter #(.MEM_LAT(LAT), .DBG_MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );
  punc_dmem_arbiter #(.MEM_LAT(LAT3), .DBG_MAX_WAIT(MAXW)) dut3 (
    .clk(clk), .rst(rst),
    .cpu_req(l3_req), .cpu_we(1'b0), .cpu_addr(l3_addr), .cpu_wdata(16'h0),
    .cpu_ack(l3_ack), .cpu_rdata(l3_rdata),
    .dbg_req(1'b0), .dbg_we(1'b0), .dbg_addr(16'h0), .dbg_wdata(16'h0),
    .dbg_ack(l3_dack), .dbg_rdata(l3_drdata),
    .mem_en(l3_mem_en), .mem_we(l3_mem_we), .mem_addr(l3_mem_addr), .mem_wdata(l3_mem_wdata),
    .mem_rdata(l3_mem_rdata), .busy(l3_busy)
  );
  int tests = 0, fails = 0;
  int cyc = 0, en_c = 0, ack_c = 0, rd_at = -1, starve = 0;
  bit act = 0, own_dbg = 0, m_we = 0;
  logic [15:0] m_addr, m_wdata, m_rd, rd_addr;
  logic [15:0] last_addr = 0, last_wdata = 0, exp_cpu_rd = 0, exp_dbg_rd = 0;
  logic [15:0] mem [65536];
  logic [15:0] ref_mem [65536];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask
  function automatic logic [15:0] pick();
    return $urandom_range(3) == 0 ? 16'h0040 : (16'h3000 | 16'($urandom_range(7)));
  endfunction
  task automatic step(input int p_req, input int p_rst, input bit hold);
    bit go_dbg;
    if (act && cyc == ack_c && !m_we) begin
      if (own_dbg) exp_dbg_rd = m_rd;
      else exp_cpu_rd = m_rd;
    end
    chk("busy", busy, act && cyc >= en_c && cyc <= ack_c);
    chk("mem_en", mem_en, act && cyc == en_c);
    chk("mem_we", mem_we, act && cyc == en_c && m_we);
    chk("mem_addr", mem_addr, last_addr);
    chk("mem_wdata", mem_wdata, last_wdata);
    chk("cpu_ack", cpu_ack, act && cyc == ack_c && !own_dbg);
    chk("dbg_ack", dbg_ack, act && cyc == ack_c && own_dbg);
    chk("cpu_rdata", cpu_rdata, exp_cpu_rd);
    chk("dbg_rdata", dbg_rdata, exp_dbg_rd);
    if (mem_en) begin
      rd_at = cyc + LAT;
      rd_addr = mem_addr;
      if (mem_we) mem[mem_addr] = mem_wdata;
    end
    mem_rdata = (cyc == rd_at) ? mem[rd_addr] : 16'($urandom);
    if (!hold) begin
      rst = p_rst > 0 && $urandom_range(99) < p_rst;
      if (rst) begin
        cpu_req = 0;
        dbg_req = 0;
      end else begin
        if (cpu_ack || !cpu_req) begin
          cpu_req = $urandom_range(99) < p_req;
          cpu_we = 1'($urandom_range(1));
          cpu_addr = pick();
          cpu_wdata = 16'($urandom);
        end else if (act && !own_dbg && cyc >= en_c) begin
          cpu_addr = 16'($urandom);
          cpu_wdata = 16'($urandom);
          cpu_we = 1'($urandom_range(1));
        end
        if (dbg_ack || !dbg_req) begin
          dbg_req = $urandom_range(99) < p_req;
          dbg_we = 1'($urandom_range(1));
          dbg_addr = pick();
          dbg_wdata = 16'($urandom);
        end else if (act && own_dbg && cyc >= en_c) begin
          dbg_addr = 16'($urandom);
          dbg_wdata = 16'($urandom);
          dbg_we = 1'($urandom_range(1));
        end
      end
    end
    if (rst) begin
      act = 0;
      starve = 0;
      exp_cpu_rd = 0;
      exp_dbg_rd = 0;
      last_addr = 0;
      last_wdata = 0;
    end else if ((!act || cyc > ack_c) && (cpu_req || dbg_req)) begin
      go_dbg = dbg_req && (!cpu_req || starve == MAXW);
      starve = go_dbg ? 0 : (dbg_req ? (starve < MAXW ? starve + 1 : MAXW) : starve);
      act = 1;
      own_dbg = go_dbg;
      en_c = cyc + 1;
      ack_c = cyc + 2 + LAT;
      m_we = go_dbg ? dbg_we : cpu_we;
      m_addr = go_dbg ? dbg_addr : cpu_addr;
      m_wdata = go_dbg ? dbg_wdata : cpu_wdata;
      last_addr = m_addr;
      last_wdata = m_wdata;
      if (m_we) ref_mem[m_addr] = m_wdata;
      else m_rd = ref_mem[m_addr];
    end
    cyc++;
  endtask
  task automatic txn(input bit d, input bit we, input logic [15:0] a, input logic [15:0] wd, input bit move_addr);
    bit got;
    got = 0;
    @(negedge clk);
    if (d) begin dbg_req = 1; dbg_we = we; dbg_addr = a; dbg_wdata = wd; end
    else begin cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = wd; end
    step(0, 0, 1);
    for (int n = 1; n <= 20 && !got; n++) begin
      @(negedge clk);
      if (move_addr && n == 2) cpu_addr = 16'h4000;
      step(0, 0, 1);
      if (cpu_ack || dbg_ack) begin
        got = 1;
        chk("ack_lat", n, 2 + LAT);
        cpu_req = 0;
        dbg_req = 0;
      end
    end
    if (!got) begin
      chk("ack_timeout", 0, 1);
      cpu_req = 0;
      dbg_req = 0;
    end
  endtask
  initial begin
    bit got;
    int en_at;
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 16'(i) ^ 16'hA5A5;
      ref_mem[i] = mem[i];
    end
    mem[16'h3000] = 16'h1234;
    ref_mem[16'h3000] = 16'h1234;
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    step(0, 0, 1);
    rst = 0;
    @(negedge clk);
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h3000;
    step(0, 0, 1);
    @(negedge clk);
    step(0, 0, 1);
    @(negedge clk);
    rst = 1;
    cpu_req = 0;
    step(0, 0, 1);
    repeat (3) begin
      @(negedge clk);
      step(0, 0, 1);
    end
    rst = 0;
    @(negedge clk);
    step(0, 0, 1);
    txn(0, 0, 16'h3000, 16'h0, 0);
    txn(1, 1, 16'h0040, 16'hBEEF, 0);
    txn(1, 0, 16'h0040, 16'h0, 0);
    txn(0, 0, 16'h3000, 16'h0, 1);
    repeat (2500) begin
      @(negedge clk);
      step(60, 1, 0);
    end
    repeat (400) begin
      @(negedge clk);
      step(100, 0, 0);
    end
    @(negedge clk);
    rst = 0;
    cpu_req = 0;
    dbg_req = 0;
    repeat (8) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      l3_req = 1;
      l3_addr = 16'h3000 + 16'(k);
      en_at = -1;
      got = 0;
      for (int n = 1; n <= 12 && !got; n++) begin
        @(negedge clk);
        if (l3_mem_en) begin
          en_at = n;
          chk("l3_mem_addr", l3_mem_addr, 16'h3000 + 16'(k));
        end
        l3_mem_rdata = (en_at >= 0 && n == en_at + LAT3) ? (l3_mem_addr ^ 16'h5A5A) : 16'($urandom);
        if (l3_ack) begin
          got = 1;
          chk("l3_ack_lat", n, 5);
          chk("l3_en_lat", en_at, 1);
          chk("l3_rdata", l3_rdata, (16'h3000 + 16'(k)) ^ 16'h5A5A);
          l3_req = 0;
        end
      end
      if (!got) begin
        chk("l3_timeout", 0, 1);
        l3_req = 0;
      end
      @(negedge clk);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
